// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Holds segment encodings, BCD width, scan FSM states and the counter-width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int         BCD_W     = 4;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the scan controller: requester presents digit codes and enables
// with valid, controller answers with ready.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    import seg7_pkg::*;

    logic                          i_valid;
    logic                          o_ready;
    logic [BCD_W*NUM_DIGITS-1:0]   i_data;
    logic [NUM_DIGITS-1:0]         i_en;

    modport master (
        output i_valid,
        output i_data,
        output i_en,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_en,
        output o_ready
    );

endinterface

// File: rtl/seg7_scan_ctrl_display7.sv
// Combinational BCD to 7-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
// Codes above 9 decode to a dark digit.
module display7
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank with blanking
// and frame-aligned writes. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_ctrl_if.slave       wr,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [6:0]            o_seg,
    output logic                  o_frame_tick
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int DIG_W = cnt_width(NUM_DIGITS);
    localparam int DATA_W = BCD_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] LAST_DIG   = DIG_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIG_W-1:0]       digit_q, digit_d;

    logic [DATA_W-1:0]      active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0]  active_en_q, active_en_d;
    logic [DATA_W-1:0]      shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]  shadow_en_q, shadow_en_d;
    logic                   pending_q, pending_d;

    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   tick_q, tick_d;

    logic                   slot_end;
    logic                   boundary;
    logic                   accept;
    logic                   drive_on;
    logic [NUM_DIGITS-1:0]  en_eff;
    logic [BCD_W-1:0]       cur_code;
    logic [6:0]             cur_seg;
    logic [BCD_W-1:0]       code_arr [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
            assign code_arr[gi] = active_data_q[gi*BCD_W +: BCD_W];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Active data only changes at the frame boundary, so evaluating continuously
    // is equivalent to evaluating once per frame.
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        en_eff       = active_en_q;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (active_en_q[k]) begin
                if (code_arr[k] != '0)
                    seen_nonzero = 1'b1;
                else if (!seen_nonzero)
                    en_eff[k] = 1'b0;
            end
        end
    end
`else
    assign en_eff = active_en_q;
`endif

    assign cur_code = code_arr[digit_q];

    display7 u_display7 (
        .bcd_i (cur_code),
        .seg_o (cur_seg)
    );

    always_comb begin
        slot_end = (state_q == S_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DRIVE_LAST);
        boundary = (state_q == S_DRIVE) && slot_end && (digit_q == LAST_DIG);
        accept   = wr.i_valid && !pending_q;
        drive_on = (state_q == S_DRIVE) && en_eff[digit_q];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        if (slot_end) begin
            cnt_d   = '0;
            state_d = (state_q == S_BLANK) ? S_DRIVE : S_BLANK;
            if (state_q == S_DRIVE)
                digit_d = (digit_q == LAST_DIG) ? '0 : digit_q + 1'b1;
        end
    end

    // accept implies pending_q == 0, so a write in the boundary cycle never
    // reaches the active registers until the following boundary.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        active_data_d = active_data_q;
        active_en_d   = active_en_q;
        pending_d     = pending_q;
        if (boundary && pending_q) begin
            active_data_d = shadow_data_q;
            active_en_d   = shadow_en_q;
            pending_d     = 1'b0;
        end
        if (accept) begin
            shadow_data_d = wr.i_data;
            shadow_en_d   = wr.i_en;
            pending_d     = 1'b1;
        end
    end

    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        tick_d = boundary;
        if (drive_on) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_d = cur_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BLANK;
            cnt_q         <= '0;
            digit_q       <= '0;
            active_data_q <= '0;
            active_en_q   <= '0;
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            pending_q     <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            active_data_q <= active_data_d;
            active_en_q   <= active_en_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            tick_q        <= tick_d;
        end
    end

    assign wr.o_ready   = !pending_q;
    assign o_an         = an_q;
    assign o_seg        = seg_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed and random writes compared
// cycle by cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          tick;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) wr ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .o_an         (an),
        .o_seg        (seg),
        .o_frame_tick (tick)
    );

    int          checks = 0;
    int          passed = 0;
    int          t;
    logic [15:0] act_d, sh_d, prev_d;
    logic [3:0]  act_e, sh_e, prev_e;
    bit          pend;
    logic [6:0]  seg_tab [16];

    function automatic logic [3:0] eff_en(input logic [15:0] d, input logic [3:0] e);
        logic [3:0] r;
        r = e;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit nz;
            nz = 1'b0;
            for (int k = ND - 1; k >= 1; k--) begin
                if (e[k]) begin
                    if (d[k*4 +: 4] != 4'd0) nz = 1'b1;
                    else if (!nz) r[k] = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, t);
    endtask

    task automatic model_reset();
        t      = 0;
        act_d  = '0; act_e  = '0;
        sh_d   = '0; sh_e   = '0;
        prev_d = '0; prev_e = '0;
        pend   = 1'b0;
    endtask

    // Output at cycle t reflects the slot position and active data of cycle t-1.
    task automatic check_outputs();
        logic [3:0] ea, en_v;
        logic [6:0] es;
        logic       et;
        int         p, dig;
        ea = '1; es = 7'h7F; et = 1'b0;
        if (t > 0) begin
            p    = t - 1;
            dig  = (p / DIV) % ND;
            en_v = eff_en(prev_d, prev_e);
            if (((p % DIV) >= BLK) && en_v[dig]) begin
                ea = ~(4'(1) << dig);
                es = seg_tab[prev_d[dig*4 +: 4]];
            end
            et = ((t % FRAME) == 0);
        end
        chk("an", an, ea);
        chk("seg", seg, es);
        chk("tick", tick, et);
        chk("ready", wr.o_ready, !pend);
    endtask

    task automatic cycle();
        bit accept, boundary;
        check_outputs();
        @(posedge clk);
        accept   = wr.i_valid && !pend;
        boundary = ((t % FRAME) == FRAME - 1);
        prev_d   = act_d;
        prev_e   = act_e;
        if (boundary && pend) begin
            act_d = sh_d; act_e = sh_e; pend = 1'b0;
        end
        if (accept) begin
            sh_d = wr.i_data; sh_e = wr.i_en; pend = 1'b1;
            $display("write accepted at cycle %0d: data=%h en=%b", t, wr.i_data, wr.i_en);
        end
        t++;
        @(negedge clk);
        if (accept) wr.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle_until(input int ph);
        for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) cycle();
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] e);
        wr.i_data  = d;
        wr.i_en    = e;
        wr.i_valid = 1'b1;
        for (int i = 0; i < 200 && wr.i_valid; i++) cycle();
        if (wr.i_valid) begin
            checks++;
            $error("FAIL send_timeout: write %h never accepted, ready=%b required 1", d, wr.o_ready);
            wr.i_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

        rst_n      = 1'b0;
        wr.i_valid = 1'b0;
        wr.i_data  = '0;
        wr.i_en    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // No writes: dark display, tick every frame
        idle(70);

        // All four digits lit
        send(16'h4321, 4'b1111);
        idle(80);

        // Alternate digits disabled
        send(16'h0909, 4'b0101);
        idle(70);

        // Out-of-range code on digit 2
        send(16'h1A34, 4'b1111);
        idle(70);

        // Back-to-back writes, then a write landing in the boundary cycle
        idle_until(5);
        send(16'h1111, 4'b1111);
        send(16'h2222, 4'b1111);
        idle(100);
        idle_until(FRAME - 1);
        send(16'h3333, 4'b1111);
        idle(80);

        // Reset while driving with a write pending
        send(16'h4321, 4'b1111);
        idle(70);
        idle_until(5);
        send(16'h8765, 4'b1111);
        idle(6);
        check_outputs();
        rst_n = 1'b0;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_tick", tick, 1'b0);
        chk("rst_ready", wr.o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(70);

        // Random writes with random idle gaps
        for (int n = 0; n < 12; n++) begin
            idle($urandom_range(0, 40));
            send(16'($urandom), 4'($urandom));
        end
        idle(70);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
